// File: rtl/spi_mem_ctrl.sv
// SPI memory controller: one byte/halfword/word read (0x03) or write (0x02) per request,
// mode 0 at clk/2, two chip selects. Data bytes go little-endian on the wire, MSB first per byte.
module spi_mem_ctrl #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_write,
  input  logic              i_sel,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs1_n,
  output logic              o_cs2_n
);

  localparam int unsigned TxW  = 8 + ADDR_W + 32;
  localparam int unsigned CntW = $clog2((ADDR_W > 32 ? ADDR_W : 32) + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StFinish} state_e;

  state_e            r_state, w_state;
  logic [CntW-1:0]   r_cnt, w_cnt;
  logic              r_sclk, w_sclk;
  logic [TxW-1:0]    r_tx, w_tx;
  logic [31:0]       r_rx, w_rx;
  logic [31:0]       r_rdata, w_rdata;
  logic              r_write, w_write;
  logic              r_sel, w_sel;
  logic [1:0]        r_size, w_size;
  logic              r_cs1_n, w_cs1_n;
  logic              r_cs2_n, w_cs2_n;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic [CntW-1:0]   w_data_bits;
  logic [31:0]       w_rx_word;
  logic [31:0]       w_wbytes;

  // Wire order is byte 0 first, so the write word is byte-reversed ahead of the MSB-first shifter.
  assign w_wbytes = {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]};

  // First received byte sits highest in r_rx; reverse back into little-endian order.
  always_comb begin
    w_data_bits = CntW'(32);
    w_rx_word   = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
    case (r_size)
      2'd0: begin
        w_data_bits = CntW'(8);
        w_rx_word   = {24'h0, r_rx[7:0]};
      end
      2'd1: begin
        w_data_bits = CntW'(16);
        w_rx_word   = {16'h0, r_rx[7:0], r_rx[15:8]};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sclk  = r_sclk;
    w_tx    = r_tx;
    w_rx    = r_rx;
    w_rdata = r_rdata;
    w_write = r_write;
    w_sel   = r_sel;
    w_size  = r_size;
    w_cs1_n = r_cs1_n;
    w_cs2_n = r_cs2_n;
    w_busy  = r_busy;
    w_done  = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state = StCmd;
          w_cnt   = CntW'(8);
          w_sclk  = 1'b0;
          w_tx    = {(i_write ? 8'h02 : 8'h03), i_addr, (i_write ? w_wbytes : 32'h0)};
          w_rx    = 32'h0;
          w_write = i_write;
          w_sel   = i_sel;
          w_size  = i_size;
          w_cs1_n = i_sel;
          w_cs2_n = ~i_sel;
          w_busy  = 1'b1;
        end
      end
      StFinish: w_state = StIdle;
      default: begin
        if (!r_sclk) begin
          w_sclk = 1'b1;
          if (r_state == StData) w_rx = {r_rx[30:0], i_miso};
        end else begin
          w_sclk = 1'b0;
          w_tx   = r_tx << 1;
          w_cnt  = r_cnt - 1'b1;
          if (r_cnt == CntW'(1)) begin
            case (r_state)
              StCmd: begin
                w_state = StAddr;
                w_cnt   = CntW'(ADDR_W);
              end
              StAddr: begin
                w_state = StData;
                w_cnt   = w_data_bits;
              end
              default: begin
                w_state = StFinish;
                w_cs1_n = 1'b1;
                w_cs2_n = 1'b1;
                w_busy  = 1'b0;
                w_done  = 1'b1;
                if (!r_write) w_rdata = w_rx_word;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_sclk  <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_write <= 1'b0;
      r_sel   <= 1'b0;
      r_size  <= '0;
      r_cs1_n <= 1'b1;
      r_cs2_n <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sclk  <= w_sclk;
      r_tx    <= w_tx;
      r_rx    <= w_rx;
      r_rdata <= w_rdata;
      r_write <= w_write;
      r_sel   <= w_sel;
      r_size  <= w_size;
      r_cs1_n <= w_cs1_n;
      r_cs2_n <= w_cs2_n;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign o_rdata = r_rdata;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sclk  = r_sclk;
  assign o_mosi  = r_tx[TxW-1];
  assign o_cs1_n = r_cs1_n;
  assign o_cs2_n = r_cs2_n;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a small SPI slave model driving miso.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic        sel = 1'b0;
  logic        miso = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [23:0] addr = 24'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy, done, sclk, mosi, cs1_n, cs2_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] st;
  int          pl, ds;
  logic        ol, saw_done;

  spi_mem_ctrl #(.ADDR_W(24)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_write (wr),
    .i_sel   (sel),
    .i_size  (size),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_busy  (busy),
    .o_done  (done),
    .o_sclk  (sclk),
    .o_mosi  (mosi),
    .i_miso  (miso),
    .o_cs1_n (cs1_n),
    .o_cs2_n (cs2_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge where done is seen.
  // t_rx holds the slave's bytes in wire order: t_rx[7:0] is sent first.
  task automatic do_txn(input string tag, input logic t_wr, input logic t_sel,
                        input logic [1:0] t_size, input logic [23:0] t_addr,
                        input logic [31:0] t_wdata, input logic [31:0] t_rx, input int poke_s,
                        output logic [63:0] stream, output int pulses, output int done_s,
                        output logic other_low);
    int   nb;
    int   p;
    logic prev_sclk;
    nb = (t_size == 2'd0) ? 1 : (t_size == 2'd1) ? 2 : 4;
    stream = '0;
    pulses = 0;
    done_s = 0;
    other_low = 1'b0;
    prev_sclk = 1'b0;
    wr = t_wr; sel = t_sel; size = t_size; addr = t_addr; wdata = t_wdata; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; wr = ~t_wr; sel = ~t_sel; size = ~t_size; addr = ~t_addr; wdata = ~t_wdata;
    for (int s = 1; s <= 200 && done_s == 0; s++) begin
      @(negedge clk);
      if (s == 1) begin
        check_eq({tag, " cs_sel_low"}, t_sel ? cs2_n : cs1_n, 0);
        check_eq({tag, " busy"}, busy, 1);
        check_eq({tag, " sclk_mosi_first"}, {sclk, mosi}, 2'b00);
      end
      if ((t_sel ? cs1_n : cs2_n) == 1'b0) other_low = 1'b1;
      if (sclk && !prev_sclk) begin
        stream = {stream[62:0], mosi};
        pulses++;
      end
      prev_sclk = sclk;
      if (done) done_s = s;
      p = pulses - 32;
      if (p >= 0 && p < 8 * nb) miso = t_rx[(p / 8) * 8 + 7 - (p % 8)];
      else miso = 1'b1;
      if (s == poke_s) begin
        start = 1'b1; wr = ~t_wr; sel = ~t_sel; size = 2'd0; addr = 24'hFFFFFF;
      end
      if (s == poke_s + 1) start = 1'b0;
    end
    if (done_s == 0) check_eq({tag, " done_timeout"}, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst cs1_n", cs1_n, 1);
    check_eq("rst cs2_n", cs2_n, 1);
    check_eq("rst sclk", sclk, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn("word_rd", 1'b0, 1'b0, 2'd2, 24'h000010, 32'h0, 32'h00100513, -1, st, pl, ds, ol);
    check_eq("word_rd stream", st[63:32], 32'h03000010);
    check_eq("word_rd pulses", pl, 64);
    check_eq("word_rd done_at", ds, 129);
    check_eq("word_rd cs2_low", ol, 0);
    check_eq("word_rd rdata", rdata, 32'h00100513);
    @(negedge clk);

    do_txn("byte_wr", 1'b1, 1'b1, 2'd0, 24'h000123, 32'hDEADBEEF, 32'h0, -1, st, pl, ds, ol);
    check_eq("byte_wr stream", st, 64'h02000123EF);
    check_eq("byte_wr pulses", pl, 40);
    check_eq("byte_wr done_at", ds, 81);
    check_eq("byte_wr cs1_low", ol, 0);
    check_eq("byte_wr rdata_kept", rdata, 32'h00100513);
    @(negedge clk);

    do_txn("half_rd", 1'b0, 1'b1, 2'd1, 24'h000200, 32'h0, 32'hFFFFCDAB, -1, st, pl, ds, ol);
    check_eq("half_rd stream", st[47:16], 32'h03000200);
    check_eq("half_rd pulses", pl, 48);
    check_eq("half_rd done_at", ds, 97);
    check_eq("half_rd rdata", rdata, 32'h0000CDAB);
    @(negedge clk);

    do_txn("poke_wr", 1'b1, 1'b0, 2'd2, 24'hABCDEF, 32'h11223344, 32'h0, 30, st, pl, ds, ol);
    check_eq("poke_wr stream", st, 64'h02ABCDEF44332211);
    check_eq("poke_wr pulses", pl, 64);
    check_eq("poke_wr done_at", ds, 129);
    check_eq("poke_wr cs2_low", ol, 0);
    @(negedge clk);
    check_eq("b2b gap done", done, 0);
    check_eq("b2b gap cs", {cs1_n, cs2_n}, 2'b11);
    do_txn("b2b_rd", 1'b0, 1'b1, 2'd0, 24'h000001, 32'h0, 32'h0000005A, -1, st, pl, ds, ol);
    check_eq("b2b_rd stream", st[39:8], 32'h03000001);
    check_eq("b2b_rd done_at", ds, 81);
    check_eq("b2b_rd rdata", rdata, 32'h0000005A);
    @(negedge clk);

    saw_done = 1'b0;
    wr = 1'b0; sel = 1'b0; size = 2'd2; addr = 24'h000040; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort cs", {cs1_n, cs2_n}, 2'b11);
    check_eq("abort sclk", sclk, 0);
    check_eq("abort busy", busy, 0);
    check_eq("abort rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_eq("abort no_done", saw_done, 0);
    do_txn("post_rd", 1'b0, 1'b0, 2'd1, 24'h000800, 32'h0, 32'h00001234, -1, st, pl, ds, ol);
    check_eq("post_rd done_at", ds, 97);
    check_eq("post_rd rdata", rdata, 32'h00001234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

SPI memory controller between the rv32e core's load/store/fetch path and the two external SPI memories: chip 1 (`cs1`, program flash) and chip 2 (`cs2`, data RAM). It accepts one byte, halfword or word access per request. Each access is serialised as a standard read (0x03) or write (0x02) command, a 24-bit address and the data bytes, in SPI mode 0 at clk/2. Its outputs drive `uo_out[5]` (sclk), `uo_out[3]` (mosi), `uo_out[4]` (cs1) and `uio_out[0]` (cs2); `miso` arrives on `ui_in[2]`.

## Interface
- `ADDR_W`, 24: address bits sent on the wire, MSB first.
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `start` in 1: request strobe; sampled only when `busy`=0.
- `write` in 1: 1 = write (0x02), 0 = read (0x03); captured at start.
- `sel` in 1: 0 = chip 1 (`cs1_n`), 1 = chip 2 (`cs2_n`); captured at start.
- `size` in 2: 0 = byte, 1 = halfword, 2 or 3 = word; captured at start.
- `addr` in ADDR_W: byte address; captured at start.
- `wdata` in 32: write data; captured at start.
- `rdata` out 32: read result; zero-extended; valid from the `done` cycle until the next `done`.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `sclk` out 1: SPI clock, idle low.
- `mosi` out 1: SPI data out.
- `miso` in 1: SPI data in.
- `cs1_n` out 1: chip 1 select, active-low.
- `cs2_n` out 1: chip 2 select, active-low.

## Operation
- States:
  - IDLE: `start` → CMD.
  - CMD: 8 bits, then → ADDR.
  - ADDR: ADDR_W bits, then → DATA.
  - DATA: 8×nbytes bits, then → FINISH.
  - FINISH: one cycle, then → IDLE.
- nbytes = 1, 2 or 4 from `size`. Total bits N = 8 + ADDR_W + 8·nbytes, e.g. 40, 48 or 64 with ADDR_W=24.
- Bit ordering:
  - Command and address are sent MSB first.
  - Data is little-endian by byte. The first byte on the wire is `wdata[7:0]` on writes and lands in `rdata[7:0]` on reads. Within each byte, MSB first.
- Reads: `miso` is shifted in on the data-phase rising edges only. `rdata` updates atomically in the `done` cycle, with unused upper bytes set to 0. `miso` is ignored during CMD and ADDR.
- Writes: `rdata` is unchanged.
- Exactly one chip select is low during a transaction, chosen by the captured `sel`. The other stays high.
- `start` while `busy`=1 is ignored; there is no queueing. Request inputs may change freely after the start cycle.
- Address is not range-checked. Bits above ADDR_W are not present.

## Timing
- Reset values: `sclk`=0, `mosi`=0, `cs1_n`=1, `cs2_n`=1, `busy`=0, `done`=0, `rdata`=0, state IDLE.
- `rst_n` low mid-transaction aborts on that edge: outputs return to reset values and no `done` is issued.
- Let T be the edge where `start`=1 is sampled in IDLE:
  - T+1: selected cs goes low, `busy`=1, `sclk`=0, `mosi` = bit 0 of the stream (command MSB).
  - Stream bit k (k=0..N-1) is presented on `mosi` with `sclk` low at T+1+2k.
  - `sclk` rises at T+2+2k, where `miso` is sampled, and falls at T+3+2k, where `mosi` moves to bit k+1.
  - T+2N+1: `sclk`=0, cs high, `done`=1, `busy`=0, `rdata` updated.
  - T+2N+2: `done`=0. A new `start` is accepted in this cycle, so the earliest next cs-low is T+2N+3.
- Latency `start`→`done`: byte 81, halfword 97, word 129 clocks with ADDR_W=24.
- `mosi` holds its last value when idle; it only needs to be valid while cs is low. Bus mode 0: `sclk` idles low, and data is stable across each rising edge.

## Test plan
- Reset: hold `rst_n`=0 for 3 clocks → `cs1_n`=`cs2_n`=1, `sclk`=0, `busy`=0, `done`=0, `rdata`=0.
- Word read from chip 1:
  - Stimulus: `addr`=0x000010, `sel`=0, `size`=2. The model returns bytes 0x13, 0x05, 0x10, 0x00.
  - Required: `mosi` stream 0x03, 0x00, 0x00, 0x10; `cs2_n` stays 1; `done` at T+129; `rdata`=0x00100513.
- Byte write to chip 2:
  - Stimulus: `addr`=0x000123, `wdata`=0xDEADBEEF, `size`=0, `sel`=1.
  - Required: stream 0x02, 0x00, 0x01, 0x23, 0xEF; 40 `sclk` pulses; `done` at T+81; `cs1_n` stays 1; `rdata` unchanged.
- Halfword read:
  - Stimulus: model returns 0xAB, 0xCD, 0xFF, 0xFF.
  - Required: `rdata`=0x0000CDAB; cs rises after exactly 48 pulses.
- `start` re-asserted while `busy`: ignored, so the stream and `done` count are unaffected. Then `start` in the T+2N+2 cycle → next cs low at T+2N+3.
- `rst_n` pulsed low at the 20th clock of a word read: cs high and `sclk`=0 on that edge, with no `done`. A following read completes correctly.
